box_plotter: RTL and testbench
==============================

# box_plotter

Parametrised rectangle-drawing datapath for the Simon Says VGA front end. It accepts a box request (origin, size, colour, mode) through a start/ready handshake. It then walks the box in raster order, emitting one pixel coordinate, colour and plot strobe per cycle to the VGA adapter, with on-screen clipping. It replaces the fixed 4x4 pass-through datapath and sits between the game FSM and the VGA adapter.

## Interface
Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- C_W, 3, colour width
- MAX_W, 16, maximum box width in pixels
- MAX_H, 16, maximum box height in pixels
- BG_COLOUR, 0, colour driven in erase mode

Size port widths: SW_W = clog2(MAX_W+1), SH_W = clog2(MAX_H+1).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  request strobe; accepted when start && ready
- x_in  in  X_W  box origin x (left)
- y_in  in  Y_W  box origin y (top)
- width_in  in  SW_W  box width; values above MAX_W clamp to MAX_W
- height_in  in  SH_W  box height; values above MAX_H clamp to MAX_H
- colour_in  in  C_W  fill colour
- mode  in  2  00 fill, 01 outline, 10 erase, 11 treated as fill
- ready  out  1  high only in IDLE
- x_out  out  X_W  pixel x
- y_out  out  Y_W  pixel y
- colour_out  out  C_W  pixel colour
- plot  out  1  pixel write enable to VGA adapter
- done  out  1  one-cycle pulse after the last pixel

## Operation
- States: IDLE, DRAW, DONE. Reset enters IDLE.
- IDLE, start=1: latch origin, clamped size, colour and mode.
  - Width or height 0: go to DONE.
  - Otherwise: clear col/row, go to DRAW.
- IDLE, start=0: stay.
- DRAW: one pixel per cycle at (x0+col, y0+row).
  - col increments 0..w-1; on col=w-1 it wraps to 0 and row increments.
  - At col=w-1, row=h-1: go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start while not in IDLE is ignored; latched request values do not change.
- Arithmetic: sums are computed X_W+1 / Y_W+1 bits wide.
- Clipping: plot=0 if the sum overflows, x ≥ SCREEN_W (160) or y ≥ SCREEN_H (120). The cycle is still consumed.
- Outline mode: plot=0 for interior pixels (col∉{0,w-1} and row∉{0,h-1}). The cycle is still consumed.
- Erase mode: colour_out=BG_COLOUR.
- Other modes: colour_out is the latched colour.
- Reset mid-operation: next cycle state=IDLE, plot=0, done=0. No further pixels are emitted.

## Timing
- x_out, y_out, colour_out, plot and done are registered.
- Reset values: x_out=0, y_out=0, colour_out=0, plot=0, done=0. ready=1 in the first cycle after the reset edge.
- Start accepted at cycle 0:
  - Pixel k (k=0..N-1, N=w*h) is valid on the outputs in cycle k+1.
  - done=1 in cycle N+1.
  - ready=1 from cycle N+2.
- Zero-size request: done=1 in cycle 1, no plot, ready=1 from cycle 2.
- Back-to-back: a start in the first ready cycle gives its first pixel one cycle later. Minimum gap between boxes is one idle cycle.
- x_out/y_out hold their last value while plot=0.

## Structure
- Package box_plotter_pkg holds:
  - the mode encoding (MODE_FILL, MODE_OUTLINE, MODE_ERASE);
  - the state enum (IDLE, DRAW, DONE);
  - SCREEN_W=160 and SCREEN_H=120.
- Sub-module raster_counter(W_MAX, H_MAX):
  - col/row counters with load, enable and wrap;
  - outputs last_col, last_row, is_border.
- Top-level: FSM, request latch, coordinate adder, clip/mode logic, output registers.

## Test plan
- Reset: hold resetn=0 for 2 cycles -> all outputs 0; ready=1 after release; no plot for 10 idle cycles.
- Fill 4x4 at (10,20), colour 3'b100 -> 16 consecutive plots, x 10..13 inner loop, y 20..23 outer loop, colour 100, done in cycle 17, ready in cycle 18.
- Outline 4x3 at (0,0), colour 3'b010 -> 12 cycles, plot=0 exactly at (1,1) and (2,1), 10 plots, done in cycle 13.
- Erase 2x2 at (50,50), colour_in 3'b111 -> 4 plots, colour_out=000.
- Clip 4x4 at (158,118) -> plots only at x∈{158,159}, y∈{118,119} (4 plots); done still in cycle 17.
- Edge cases:
  - width_in=0 -> done in cycle 1, no plot.
  - width_in=31 -> clamped to 16 columns.
  - start pulsed during DRAW -> ignored.
  - resetn=0 at pixel 5 -> plot=0 next cycle, ready=1 after release.

Source files
------------

// File: rtl/box_plotter_pkg.sv
// Shared definitions for the box plotter datapath.
//   - mode encoding of the request's mode field
//   - FSM state enumeration
//   - visible screen dimensions used for clipping
package box_plotter_pkg;

    localparam logic [1:0] MODE_FILL    = 2'b00;
    localparam logic [1:0] MODE_OUTLINE = 2'b01;
    localparam logic [1:0] MODE_ERASE   = 2'b10;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DRAW = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/box_plotter_raster.sv
// raster_counter: column/row walker for a box of size w x h.
// The counter holds the position of the pixel most recently emitted.
// next_col/next_row give the position that follows it in raster order,
// and is_border tells whether that following position lies on the box edge.
// last_col/last_row describe the current position, so last_col && last_row
// marks the final pixel of the box.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   load             clear col/row to 0
//   enable           advance to the next raster position
//   w, h             box size (both >= 1 while enabled)
//   next_col/row     position following the current one
//   last_col/row     current column/row is the last one
//   is_border        next position lies on the outline
module raster_counter #(
    parameter int W_MAX = 16,
    parameter int H_MAX = 16,
    parameter int CW    = $clog2(W_MAX + 1),
    parameter int RW    = $clog2(H_MAX + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic          enable,
    input  logic [CW-1:0] w,
    input  logic [RW-1:0] h,
    output logic [CW-1:0] next_col,
    output logic [RW-1:0] next_row,
    output logic          last_col,
    output logic          last_row,
    output logic          is_border
);

    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [RW-1:0] ONE_R = RW'(1);

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;

    // Wrap detection and the following raster position.
    always_comb begin
        last_col = (col_r == (w - ONE_C));
        last_row = (row_r == (h - ONE_R));
        if (last_col) begin
            next_col = {CW{1'b0}};
            next_row = row_r + ONE_R;
        end else begin
            next_col = col_r + ONE_C;
            next_row = row_r;
        end
        is_border = (next_col == {CW{1'b0}}) || (next_col == (w - ONE_C)) ||
                    (next_row == {RW{1'b0}}) || (next_row == (h - ONE_R));
    end

    // Column/row registers: clear on load, step on enable.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else if (load) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else if (enable) begin
            col_r <= next_col;
            row_r <= next_row;
        end
    end

endmodule

// File: rtl/box_plotter.sv
// box_plotter: walks a requested rectangle in raster order and emits one
// pixel (x, y, colour, plot) per cycle to the VGA adapter, clipping pixels
// that fall off screen and suppressing interior pixels in outline mode.
// Pixel 0 is produced at the accepting edge directly from the request
// inputs; every later pixel comes from the raster counter's next position,
// so pixel k appears k+1 cycles after the start is accepted.
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   start / ready                   request handshake (ready only in IDLE)
//   x_in, y_in                      box origin (top-left)
//   width_in, height_in             box size, clamped to MAX_W / MAX_H
//   colour_in, mode                 fill colour, 00 fill 01 outline 10 erase
//   x_out, y_out, colour_out, plot  registered pixel stream
//   done                            one-cycle pulse after the last pixel
module box_plotter
    import box_plotter_pkg::*;
#(
    parameter int  X_W       = 8,
    parameter int  Y_W       = 7,
    parameter int  C_W       = 3,
    parameter int  MAX_W     = 16,
    parameter int  MAX_H     = 16,
    parameter int  BG_COLOUR = 0,
    localparam int SW_W      = $clog2(MAX_W + 1),
    localparam int SH_W      = $clog2(MAX_H + 1)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [X_W-1:0]  x_in,
    input  logic [Y_W-1:0]  y_in,
    input  logic [SW_W-1:0] width_in,
    input  logic [SH_W-1:0] height_in,
    input  logic [C_W-1:0]  colour_in,
    input  logic [1:0]      mode,
    output logic            ready,
    output logic [X_W-1:0]  x_out,
    output logic [Y_W-1:0]  y_out,
    output logic [C_W-1:0]  colour_out,
    output logic            plot,
    output logic            done
);

    state_t          state_r;
    logic [X_W-1:0]  x0_r;
    logic [Y_W-1:0]  y0_r;
    logic [SW_W-1:0] w_r;
    logic [SH_W-1:0] h_r;
    logic [C_W-1:0]  colour_r;
    logic [1:0]      mode_r;

    logic [X_W-1:0]  x_out_r;
    logic [Y_W-1:0]  y_out_r;
    logic [C_W-1:0]  colour_out_r;
    logic            plot_r;
    logic            done_r;

    logic [SW_W-1:0] w_clamp_s;
    logic [SH_W-1:0] h_clamp_s;
    logic            load_s;
    logic            enable_s;
    logic [SW_W-1:0] next_col_s;
    logic [SH_W-1:0] next_row_s;
    logic            last_col_s;
    logic            last_row_s;
    logic            is_border_s;

    logic [X_W-1:0]  base_x_s;
    logic [Y_W-1:0]  base_y_s;
    logic [SW_W-1:0] pix_col_s;
    logic [SH_W-1:0] pix_row_s;
    logic            border_s;
    logic [1:0]      mode_s;
    logic [C_W-1:0]  colour_s;
    logic [X_W:0]    sum_x_s;
    logic [Y_W:0]    sum_y_s;
    logic            on_screen_s;
    logic            plot_s;
    logic [C_W-1:0]  pix_colour_s;

    // Clamp the requested size to the supported maximum.
    always_comb begin
        if (width_in > SW_W'(MAX_W)) begin
            w_clamp_s = SW_W'(MAX_W);
        end else begin
            w_clamp_s = width_in;
        end
        if (height_in > SH_W'(MAX_H)) begin
            h_clamp_s = SH_W'(MAX_H);
        end else begin
            h_clamp_s = height_in;
        end
    end

    // Counter control: clear on acceptance, step while pixels remain.
    always_comb begin
        load_s   = (state_r == IDLE) && start;
        enable_s = (state_r == DRAW) && !(last_col_s && last_row_s);
    end

    raster_counter #(
        .W_MAX (MAX_W),
        .H_MAX (MAX_H)
    ) u_raster (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load_s),
        .enable    (enable_s),
        .w         (w_r),
        .h         (h_r),
        .next_col  (next_col_s),
        .next_row  (next_row_s),
        .last_col  (last_col_s),
        .last_row  (last_row_s),
        .is_border (is_border_s)
    );

    // Select the pixel to emit at the next edge, add, clip and apply mode.
    always_comb begin
        if (state_r == IDLE) begin
            // Pixel 0 is always (0,0), which is always on the outline.
            base_x_s  = x_in;
            base_y_s  = y_in;
            pix_col_s = {SW_W{1'b0}};
            pix_row_s = {SH_W{1'b0}};
            border_s  = 1'b1;
            mode_s    = mode;
            colour_s  = colour_in;
        end else begin
            base_x_s  = x0_r;
            base_y_s  = y0_r;
            pix_col_s = next_col_s;
            pix_row_s = next_row_s;
            border_s  = is_border_s;
            mode_s    = mode_r;
            colour_s  = colour_r;
        end
        sum_x_s = {1'b0, base_x_s} + (X_W + 1)'(pix_col_s);
        sum_y_s = {1'b0, base_y_s} + (Y_W + 1)'(pix_row_s);
        on_screen_s = !sum_x_s[X_W] && !sum_y_s[Y_W] &&
                      (32'(sum_x_s[X_W-1:0]) < SCREEN_W) &&
                      (32'(sum_y_s[Y_W-1:0]) < SCREEN_H);
        if (mode_s == MODE_OUTLINE) begin
            plot_s = on_screen_s && border_s;
        end else begin
            plot_s = on_screen_s;
        end
        if (mode_s == MODE_ERASE) begin
            pix_colour_s = C_W'(BG_COLOUR);
        end else begin
            pix_colour_s = colour_s;
        end
    end

    // FSM, request latch and registered pixel outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= IDLE;
            x0_r         <= {X_W{1'b0}};
            y0_r         <= {Y_W{1'b0}};
            w_r          <= {SW_W{1'b0}};
            h_r          <= {SH_W{1'b0}};
            colour_r     <= {C_W{1'b0}};
            mode_r       <= 2'b00;
            x_out_r      <= {X_W{1'b0}};
            y_out_r      <= {Y_W{1'b0}};
            colour_out_r <= {C_W{1'b0}};
            plot_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        x0_r     <= x_in;
                        y0_r     <= y_in;
                        w_r      <= w_clamp_s;
                        h_r      <= h_clamp_s;
                        colour_r <= colour_in;
                        mode_r   <= mode;
                        if ((w_clamp_s == {SW_W{1'b0}}) || (h_clamp_s == {SH_W{1'b0}})) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                            plot_r  <= 1'b0;
                        end else begin
                            state_r <= DRAW;
                            plot_r  <= plot_s;
                            if (plot_s) begin
                                x_out_r      <= sum_x_s[X_W-1:0];
                                y_out_r      <= sum_y_s[Y_W-1:0];
                                colour_out_r <= pix_colour_s;
                            end
                        end
                    end else begin
                        plot_r <= 1'b0;
                    end
                end
                DRAW: begin
                    if (last_col_s && last_row_s) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                        plot_r  <= 1'b0;
                    end else begin
                        plot_r <= plot_s;
                        if (plot_s) begin
                            x_out_r      <= sum_x_s[X_W-1:0];
                            y_out_r      <= sum_y_s[Y_W-1:0];
                            colour_out_r <= pix_colour_s;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    plot_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    plot_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = (state_r == IDLE);
    assign x_out      = x_out_r;
    assign y_out      = y_out_r;
    assign colour_out = colour_out_r;
    assign plot       = plot_r;
    assign done       = done_r;

endmodule

// File: tb/tb_box_plotter.sv
// Directed bench for box_plotter: reset, fill, outline, erase, clipping,
// size clamping, zero size, ignored start during drawing and mid-box reset.
module tb_box_plotter;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x_in = 8'd0;
    logic [6:0] y_in = 7'd0;
    logic [4:0] width_in = 5'd0;
    logic [4:0] height_in = 5'd0;
    logic [2:0] colour_in = 3'd0;
    logic [1:0] mode = 2'b00;
    logic       ready;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       done;

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] last_x = 8'd0;
    logic [6:0] last_y = 7'd0;

    box_plotter dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .x_in       (x_in),
        .y_in       (y_in),
        .width_in   (width_in),
        .height_in  (height_in),
        .colour_in  (colour_in),
        .mode       (mode),
        .ready      (ready),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, "_ready_wait"}, ready, 1);
    endtask

    // Issue one box and check every pixel cycle, done and ready timing.
    task automatic draw_box(input string name, input logic [7:0] bx, input logic [6:0] by,
                            input logic [4:0] bw, input logic [4:0] bh, input logic [2:0] bc,
                            input logic [1:0] bm, input int cols, input int rows,
                            input int exp_plots, input bit inject);
        int plots;
        int col;
        int row;
        int ex;
        int ey;
        bit border;
        bit ep;
        logic [2:0] ecol;
        plots = 0;
        wait_ready(name);
        x_in = bx; y_in = by; width_in = bw; height_in = bh;
        colour_in = bc; mode = bm; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < cols * rows; k++) begin
            col = k % cols;
            row = k / cols;
            ex = int'(bx) + col;
            ey = int'(by) + row;
            border = (col == 0) || (col == cols - 1) || (row == 0) || (row == rows - 1);
            ep = (ex < 160) && (ey < 120) && ((bm != 2'b01) || border);
            ecol = (bm == 2'b10) ? 3'b000 : bc;
            check({name, "_plot"}, plot, ep);
            check({name, "_done_low"}, done, 0);
            if (ep) begin
                check({name, "_x"}, x_out, ex);
                check({name, "_y"}, y_out, ey);
                check({name, "_colour"}, colour_out, ecol);
                last_x = ex[7:0];
                last_y = ey[6:0];
                plots++;
            end else begin
                check({name, "_x_hold"}, x_out, last_x);
                check({name, "_y_hold"}, y_out, last_y);
            end
            if (inject && k == 3) begin
                start = 1'b1; x_in = 8'd99; y_in = 7'd9; width_in = 5'd1;
                height_in = 5'd1; colour_in = 3'b001; mode = 2'b10;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check({name, "_done"}, done, 1);
        check({name, "_done_plot"}, plot, 0);
        check({name, "_done_ready"}, ready, 0);
        tick();
        check({name, "_done_pulse"}, done, 0);
        check({name, "_ready_back"}, ready, 1);
        check({name, "_plot_count"}, plots, exp_plots);
    endtask

    initial begin
        int cnt;
        // Reset held for two cycles.
        resetn = 1'b0;
        tick();
        tick();
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        check("rst_colour", colour_out, 0);
        check("rst_plot", plot, 0);
        check("rst_done", done, 0);
        resetn = 1'b1;
        check("rst_ready", ready, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (plot === 1'b1) cnt++;
        end
        check("idle_plots", cnt, 0);

        draw_box("fill", 8'd10, 7'd20, 5'd4, 5'd4, 3'b100, 2'b00, 4, 4, 16, 1'b1);
        draw_box("outline", 8'd0, 7'd0, 5'd4, 5'd3, 3'b010, 2'b01, 4, 3, 10, 1'b0);
        draw_box("erase", 8'd50, 7'd50, 5'd2, 5'd2, 3'b111, 2'b10, 2, 2, 4, 1'b0);
        draw_box("clip", 8'd158, 7'd118, 5'd4, 5'd4, 3'b011, 2'b00, 4, 4, 4, 1'b0);
        draw_box("clamp", 8'd0, 7'd5, 5'd31, 5'd1, 3'b101, 2'b11, 16, 1, 16, 1'b0);

        // Zero-width request: done next cycle, nothing plotted.
        wait_ready("zero");
        x_in = 8'd5; y_in = 7'd5; width_in = 5'd0; height_in = 5'd4;
        colour_in = 3'b110; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_plot", plot, 0);
        check("zero_ready_low", ready, 0);
        tick();
        check("zero_ready", ready, 1);
        check("zero_done_pulse", done, 0);
        check("zero_plot2", plot, 0);

        // Reset while pixel 5 of a 4x4 fill is on the outputs.
        wait_ready("rstmid");
        x_in = 8'd30; y_in = 7'd30; width_in = 5'd4; height_in = 5'd4;
        colour_in = 3'b110; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rstmid_pix5_plot", plot, 1);
        check("rstmid_pix5_x", x_out, 31);
        check("rstmid_pix5_y", y_out, 31);
        resetn = 1'b0;
        tick();
        check("rstmid_plot", plot, 0);
        check("rstmid_done", done, 0);
        resetn = 1'b1;
        tick();
        check("rstmid_ready", ready, 1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (plot === 1'b1) cnt++;
            tick();
        end
        check("rstmid_no_pixels", cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
